// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared state encoding and default widths for the TDC acquisition controller
package tdc_pkg;

  localparam int TDC_DATA_W         = 16;
  localparam int TDC_SHOT_W         = 8;
  localparam int TDC_TMO_W          = 16;
  localparam int TDC_RECOVER_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_WAIT_STOP  = 3'd2,
    ST_WAIT_DATA  = 3'd3,
    ST_RECOVER    = 3'd4,
    ST_DONE       = 3'd5
  } tdc_state_e;

endpackage

// File: rtl/tdc_burst_stats.sv
// rtl/tdc_burst_stats.sv - sum/min/max/good-count accumulator for one burst
module tdc_burst_stats
  import tdc_pkg::*;
#(
  parameter int DATA_W = TDC_DATA_W,
  parameter int SHOT_W = TDC_SHOT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     update_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W+SHOT_W-1:0] sum_o,
  output logic [DATA_W-1:0]        min_o,
  output logic [DATA_W-1:0]        max_o,
  output logic [SHOT_W-1:0]        good_o
);

  logic [DATA_W+SHOT_W-1:0] sum_q;
  logic [DATA_W-1:0]        min_q;
  logic [DATA_W-1:0]        max_q;
  logic [SHOT_W-1:0]        good_q;

  // Clear starts an empty burst (min all ones so the first value always wins); update folds in one good shot.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      sum_q  <= '0;
      min_q  <= '1;
      max_q  <= '0;
      good_q <= '0;
    end else if (update_i) begin
      sum_q <= sum_q + (DATA_W+SHOT_W)'(data_i);
      if (data_i < min_q) min_q <= data_i;
      if (data_i > max_q) max_q <= data_i;
      if (good_q != '1) good_q <= good_q + SHOT_W'(1);
    end
  end

  assign sum_o  = sum_q;
  assign min_o  = min_q;
  assign max_o  = max_q;
  assign good_o = good_q;

endmodule

// File: rtl/tdc_acq_controller.sv
// rtl/tdc_acq_controller.sv - burst sequencer: gates start/stop edges to the TDC, collects results, recovers on timeout
module tdc_acq_controller
  import tdc_pkg::*;
#(
  parameter int DATA_W         = TDC_DATA_W,
  parameter int SHOT_W         = TDC_SHOT_W,
  parameter int TMO_W          = TDC_TMO_W,
  parameter int RECOVER_CYCLES = TDC_RECOVER_CYCLES
) (
  input  logic                     CLK_IN,
  input  logic                     RESET_IN,
  input  logic                     ARM_IN,
  input  logic                     ABORT_IN,
  input  logic [SHOT_W-1:0]        NUM_SHOTS_IN,
  input  logic [TMO_W-1:0]         TIMEOUT_IN,
  input  logic                     START_RAW_IN,
  input  logic                     STOP_RAW_IN,
  output logic                     START_OUT,
  output logic                     STOP_OUT,
  output logic                     TDC_RESET_OUT,
  input  logic                     DATA_VALID_IN,
  input  logic [DATA_W-1:0]        TDC_DATA_IN,
  output logic                     BUSY_OUT,
  output logic                     RESULT_VALID_OUT,
  input  logic                     RESULT_ACK_IN,
  output logic [DATA_W+SHOT_W-1:0] RESULT_SUM_OUT,
  output logic [DATA_W-1:0]        RESULT_MIN_OUT,
  output logic [DATA_W-1:0]        RESULT_MAX_OUT,
  output logic [SHOT_W-1:0]        RESULT_GOOD_OUT,
  output logic [SHOT_W-1:0]        RESULT_TMO_OUT
);

  tdc_state_e        state_q, state_d;
  logic [SHOT_W-1:0] n_q, n_d;
  logic [TMO_W-1:0]  t_q, t_d;
  logic [TMO_W-1:0]  phase_q, phase_d;
  logic [SHOT_W-1:0] attempt_q, attempt_d;
  logic [SHOT_W-1:0] tmo_q, tmo_d;
  logic              abort_q, abort_d;
  logic              start_prev_q, stop_prev_q;
  logic              start_out_q, start_out_d;
  logic              stop_out_q, stop_out_d;
  logic              stats_clear, stats_update;

  logic              start_rise, stop_rise;
  logic [TMO_W-1:0]  t_eff;
  logic [TMO_W:0]    phase_inc;
  logic              phase_expired;
  logic              recover_last;
  logic [SHOT_W-1:0] attempt_inc;
  logic [SHOT_W-1:0] tmo_inc;

  assign start_rise    = START_RAW_IN & ~start_prev_q;
  assign stop_rise     = STOP_RAW_IN & ~stop_prev_q;
  // A zero timeout would never fire, so it behaves as a one-cycle timeout.
  assign t_eff         = (t_q == '0) ? TMO_W'(1) : t_q;
  assign phase_inc     = {1'b0, phase_q} + (TMO_W+1)'(1);
  assign phase_expired = (phase_inc >= {1'b0, t_eff});
  assign recover_last  = (phase_q == TMO_W'(RECOVER_CYCLES - 1));
  assign attempt_inc   = (attempt_q == '1) ? attempt_q : attempt_q + SHOT_W'(1);
  assign tmo_inc       = (tmo_q == '1) ? tmo_q : tmo_q + SHOT_W'(1);

  // State, latched burst config, counters, edge history and the one-cycle TDC strobes.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      t_q          <= '0;
      phase_q      <= '0;
      attempt_q    <= '0;
      tmo_q        <= '0;
      abort_q      <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      start_out_q  <= 1'b0;
      stop_out_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      t_q          <= t_d;
      phase_q      <= phase_d;
      attempt_q    <= attempt_d;
      tmo_q        <= tmo_d;
      abort_q      <= abort_d;
      start_prev_q <= START_RAW_IN;
      stop_prev_q  <= STOP_RAW_IN;
      start_out_q  <= start_out_d;
      stop_out_q   <= stop_out_d;
    end
  end

  // Next state: abort beats edge/data events, which beat the phase timeout.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    t_d          = t_q;
    attempt_d    = attempt_q;
    tmo_d        = tmo_q;
    abort_d      = abort_q;
    start_out_d  = 1'b0;
    stop_out_d   = 1'b0;
    stats_clear  = 1'b0;
    stats_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ARM_IN && (NUM_SHOTS_IN != '0)) begin
          n_d         = NUM_SHOTS_IN;
          t_d         = TIMEOUT_IN;
          attempt_d   = '0;
          tmo_d       = '0;
          abort_d     = 1'b0;
          stats_clear = 1'b1;
          state_d     = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (ABORT_IN) begin
          abort_d = 1'b1;
          state_d = ST_RECOVER;
        end else if (start_rise) begin
          start_out_d = 1'b1;
          state_d     = ST_WAIT_STOP;
        end
      end
      ST_WAIT_STOP: begin
        if (ABORT_IN) begin
          abort_d = 1'b1;
          state_d = ST_RECOVER;
        end else if (stop_rise) begin
          stop_out_d = 1'b1;
          state_d    = ST_WAIT_DATA;
        end else if (phase_expired) begin
          tmo_d     = tmo_inc;
          attempt_d = attempt_inc;
          state_d   = ST_RECOVER;
        end
      end
      ST_WAIT_DATA: begin
        if (ABORT_IN) begin
          abort_d = 1'b1;
          state_d = ST_RECOVER;
        end else if (DATA_VALID_IN) begin
          stats_update = 1'b1;
          attempt_d    = attempt_inc;
          state_d      = (attempt_inc == n_q) ? ST_DONE : ST_WAIT_START;
        end else if (phase_expired) begin
          tmo_d     = tmo_inc;
          attempt_d = attempt_inc;
          state_d   = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (recover_last) begin
          if (abort_q)                state_d = ST_IDLE;
          else if (attempt_q == n_q)  state_d = ST_DONE;
          else                        state_d = ST_WAIT_START;
        end
      end
      ST_DONE: begin
        if (RESULT_ACK_IN) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Phase counter restarts on every state change; it only matters in the timed states.
    if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_WAIT_START) || (state_q == ST_DONE))
      phase_d = '0;
    else
      phase_d = phase_q + TMO_W'(1);
  end

  tdc_burst_stats #(
    .DATA_W (DATA_W),
    .SHOT_W (SHOT_W)
  ) u_stats (
    .clk_i    (CLK_IN),
    .rst_i    (RESET_IN),
    .clear_i  (stats_clear),
    .update_i (stats_update),
    .data_i   (TDC_DATA_IN),
    .sum_o    (RESULT_SUM_OUT),
    .min_o    (RESULT_MIN_OUT),
    .max_o    (RESULT_MAX_OUT),
    .good_o   (RESULT_GOOD_OUT)
  );

  assign START_OUT        = start_out_q;
  assign STOP_OUT         = stop_out_q;
  assign TDC_RESET_OUT    = (state_q == ST_RECOVER);
  assign BUSY_OUT         = (state_q != ST_IDLE);
  assign RESULT_VALID_OUT = (state_q == ST_DONE);
  assign RESULT_TMO_OUT   = tmo_q;

endmodule

// File: tb/tb_tdc_acq_controller.sv
// tb/tb_tdc_acq_controller.sv - directed self-checking bench for tdc_acq_controller
module tb_tdc_acq_controller;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        abort_in;
  logic [7:0]  num_shots;
  logic [15:0] timeout;
  logic        start_raw;
  logic        stop_raw;
  logic        start_out;
  logic        stop_out;
  logic        tdc_reset;
  logic        data_valid;
  logic [15:0] tdc_data;
  logic        busy;
  logic        res_valid;
  logic        res_ack;
  logic [23:0] res_sum;
  logic [15:0] res_min;
  logic [15:0] res_max;
  logic [7:0]  res_good;
  logic [7:0]  res_tmo;

  int n_assert = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int stop_cnt  = 0;
  int rst_cnt   = 0;
  int valid_cnt = 0;
  int s0, p0, r0, v0;

  tdc_acq_controller dut (
    .CLK_IN           (clk),
    .RESET_IN         (rst),
    .ARM_IN           (arm),
    .ABORT_IN         (abort_in),
    .NUM_SHOTS_IN     (num_shots),
    .TIMEOUT_IN       (timeout),
    .START_RAW_IN     (start_raw),
    .STOP_RAW_IN      (stop_raw),
    .START_OUT        (start_out),
    .STOP_OUT         (stop_out),
    .TDC_RESET_OUT    (tdc_reset),
    .DATA_VALID_IN    (data_valid),
    .TDC_DATA_IN      (tdc_data),
    .BUSY_OUT         (busy),
    .RESULT_VALID_OUT (res_valid),
    .RESULT_ACK_IN    (res_ack),
    .RESULT_SUM_OUT   (res_sum),
    .RESULT_MIN_OUT   (res_min),
    .RESULT_MAX_OUT   (res_max),
    .RESULT_GOOD_OUT  (res_good),
    .RESULT_TMO_OUT   (res_tmo)
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  // Pulse-width bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (start_out) start_cnt = start_cnt + 1;
    if (stop_out)  stop_cnt  = stop_cnt + 1;
    if (tdc_reset) rst_cnt   = rst_cnt + 1;
    if (res_valid) valid_cnt = valid_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm_burst(input logic [7:0] n, input logic [15:0] t);
    num_shots = n;
    timeout   = t;
    arm       = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Start rise, stop rise 'gap' cycles later, then one DATA_VALID with d.
  task automatic shot(input logic [15:0] d, input int gap);
    start_raw = 1'b1;
    step();
    start_raw = 1'b0;
    for (int i = 1; i < gap; i++) step();
    stop_raw = 1'b1;
    step();
    stop_raw   = 1'b0;
    data_valid = 1'b1;
    tdc_data   = d;
    step();
    data_valid = 1'b0;
    tdc_data   = '0;
  endtask

  task automatic ack_result();
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort_in = 1'b0; num_shots = '0; timeout = '0;
    start_raw = 1'b0; stop_raw = 1'b0; data_valid = 1'b0; tdc_data = '0; res_ack = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("reset_busy",  busy, 0);
    chk("reset_valid", res_valid, 0);
    chk("reset_min",   res_min, 16'hFFFF);
    chk("reset_sum",   res_sum, 0);
    chk("reset_tdcrst", tdc_reset, 0);

    // Single shot, stop two cycles after start.
    arm_burst(8'd1, 16'd20);
    chk("t1_busy", busy, 1);
    s0 = start_cnt; p0 = stop_cnt;
    shot(16'h0123, 2);
    chk("t1_start_pulses", start_cnt - s0, 1);
    chk("t1_stop_pulses",  stop_cnt - p0, 1);
    chk("t1_valid", res_valid, 1);
    chk("t1_sum",  res_sum, 24'h000123);
    chk("t1_min",  res_min, 16'h0123);
    chk("t1_max",  res_max, 16'h0123);
    chk("t1_good", res_good, 1);
    chk("t1_tmo",  res_tmo, 0);
    step();
    step();
    chk("t1_hold_valid", res_valid, 1);
    chk("t1_hold_sum",   res_sum, 24'h000123);
    ack_result();
    chk("t1_ack_valid", res_valid, 0);
    chk("t1_ack_busy",  busy, 0);
    chk("t1_retain_sum", res_sum, 24'h000123);

    // Three shots.
    arm_burst(8'd3, 16'd20);
    shot(16'd10, 1);
    shot(16'd30, 1);
    shot(16'd20, 1);
    chk("t2_valid", res_valid, 1);
    chk("t2_sum",  res_sum, 60);
    chk("t2_min",  res_min, 10);
    chk("t2_max",  res_max, 30);
    chk("t2_good", res_good, 3);
    chk("t2_tmo",  res_tmo, 0);
    ack_result();

    // Missing stop on first shot: 5 cycles in WAIT_STOP, then 4-cycle TDC reset.
    arm_burst(8'd2, 16'd5);
    start_raw = 1'b1;
    step();
    start_raw = 1'b0;
    r0 = rst_cnt;
    for (int i = 0; i < 4; i++) step();
    chk("t3_no_reset_yet", tdc_reset, 0);
    step();
    chk("t3_reset_on", tdc_reset, 1);
    chk("t3_tmo_count", res_tmo, 1);
    for (int i = 0; i < 3; i++) step();
    chk("t3_reset_still_on", tdc_reset, 1);
    step();
    chk("t3_reset_off", tdc_reset, 0);
    chk("t3_reset_len", rst_cnt - r0, 4);
    chk("t3_busy", busy, 1);
    shot(16'd7, 1);
    chk("t3_valid", res_valid, 1);
    chk("t3_good", res_good, 1);
    chk("t3_tmo",  res_tmo, 1);
    chk("t3_sum",  res_sum, 7);
    chk("t3_min",  res_min, 7);
    chk("t3_max",  res_max, 7);
    ack_result();

    // Start held high, start/stop rising together.
    arm_burst(8'd1, 16'd20);
    s0 = start_cnt; p0 = stop_cnt;
    start_raw = 1'b1;
    stop_raw  = 1'b1;
    step();
    stop_raw = 1'b0;
    for (int i = 1; i < 10; i++) step();
    start_raw = 1'b0;
    step();
    chk("t4_one_start", start_cnt - s0, 1);
    chk("t4_no_stop",   stop_cnt - p0, 0);
    stop_raw = 1'b1;
    step();
    stop_raw = 1'b0;
    step();
    chk("t4_stop_now", stop_cnt - p0, 1);
    data_valid = 1'b1;
    tdc_data   = 16'h0055;
    step();
    data_valid = 1'b0;
    chk("t4_valid", res_valid, 1);
    chk("t4_sum", res_sum, 24'h000055);
    ack_result();
    data_valid = 1'b1;
    tdc_data   = 16'h0999;
    step();
    step();
    data_valid = 1'b0;
    tdc_data   = '0;
    chk("t4_idle_dv_sum",  res_sum, 24'h000055);
    chk("t4_idle_dv_max",  res_max, 16'h0055);
    chk("t4_idle_dv_good", res_good, 1);
    chk("t4_idle_busy", busy, 0);

    // Abort in WAIT_DATA.
    arm_burst(8'd2, 16'd20);
    v0 = valid_cnt;
    start_raw = 1'b1;
    step();
    start_raw = 1'b0;
    stop_raw  = 1'b1;
    step();
    stop_raw = 1'b0;
    r0 = rst_cnt;
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    chk("t5_reset_on", tdc_reset, 1);
    for (int i = 0; i < 3; i++) step();
    chk("t5_busy_in_recover", busy, 1);
    step();
    chk("t5_busy_idle", busy, 0);
    chk("t5_reset_len", rst_cnt - r0, 4);
    step();
    chk("t5_no_valid", valid_cnt - v0, 0);
    arm_burst(8'd0, 16'd20);
    chk("t5_zero_arm_busy", busy, 0);

    // Reset mid-burst.
    arm_burst(8'd1, 16'd20);
    start_raw = 1'b1;
    step();
    start_raw = 1'b0;
    chk("t6_in_burst", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy",   busy, 0);
    chk("t6_start",  start_out, 0);
    chk("t6_tdcrst", tdc_reset, 0);
    chk("t6_valid",  res_valid, 0);
    chk("t6_min",    res_min, 16'hFFFF);
    chk("t6_sum",    res_sum, 0);
    chk("t6_good",   res_good, 0);
    arm_burst(8'd1, 16'd20);
    shot(16'h0042, 1);
    chk("t6_new_valid", res_valid, 1);
    chk("t6_new_sum",   res_sum, 24'h000042);
    chk("t6_new_good",  res_good, 1);
    ack_result();
    chk("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_acq_controller.md
Name: tdc_acq_controller

Overview:
- Sequences the oversampling TDC through a burst of N start/stop measurements. Arms the TDC, gates external start/stop edges into single-cycle TDC pulses and collects each TDC_OUTPUT word on DATA_VALID.
- Recovers from missing stops or missing results by timeout plus a TDC reset pulse.
- Sits between the raw trigger inputs/host register file and the oversampler TDC. Presents sum/min/max/count of a burst to readout via a valid/ack handshake.

Parameters:
DATA_W, 16, TDC result width
SHOT_W, 8, burst-length counter width
TMO_W, 16, timeout counter width
RECOVER_CYCLES, 4, TDC reset pulse length in cycles

Ports:
CLK_IN  in  1  system clock; all logic on rising edge
RESET_IN  in  1  synchronous, active-high reset
ARM_IN  in  1  start a burst (sampled in IDLE only)
ABORT_IN  in  1  cancel burst in progress
NUM_SHOTS_IN  in  SHOT_W  shots per burst, latched on accepted arm
TIMEOUT_IN  in  TMO_W  per-phase timeout in cycles, latched on accepted arm
START_RAW_IN  in  1  external start, synchronous level
STOP_RAW_IN  in  1  external stop, synchronous level
START_OUT  out  1  to TDC START_IN
STOP_OUT  out  1  to TDC STOP_IN
TDC_RESET_OUT  out  1  to TDC RESET_IN
DATA_VALID_IN  in  1  from TDC DATA_VALID
TDC_DATA_IN  in  DATA_W  from TDC TDC_OUTPUT
BUSY_OUT  out  1  high in every state except IDLE
RESULT_VALID_OUT  out  1  burst result available
RESULT_ACK_IN  in  1  readout consumed result
RESULT_SUM_OUT  out  DATA_W+SHOT_W  sum of good shots
RESULT_MIN_OUT  out  DATA_W  minimum good value
RESULT_MAX_OUT  out  DATA_W  maximum good value
RESULT_GOOD_OUT  out  SHOT_W  good shots in burst
RESULT_TMO_OUT  out  SHOT_W  timed-out shots in burst

Behaviour:
- Reset: state IDLE. All outputs 0, except RESULT_MIN_OUT = all ones. Counters and edge-detect registers 0.
- Edge detect: a rise means raw=1 in this cycle and raw=0 in the previous cycle. START_OUT/STOP_OUT are registered and high for exactly 1 cycle, the cycle after the rise.
- IDLE: ARM_IN=1 with NUM_SHOTS_IN!=0 does the following, then moves to WAIT_START next cycle:
  - latches N and T;
  - clears sum, good, tmo and attempt counters;
  - sets min to all ones and max to 0.
  - ARM_IN with NUM_SHOTS_IN=0 is ignored.
  - ARM_IN in any other state is ignored.
- WAIT_START: no timeout. A start rise emits START_OUT and moves to WAIT_STOP. Stop rises are ignored. If start and stop rise in the same cycle, start is taken and stop is ignored.
- WAIT_STOP: phase counter clears on entry and increments each cycle. A stop rise emits STOP_OUT and moves to WAIT_DATA. Start rises are ignored. Counter reaching T (with T=0 treated as 1) moves to RECOVER.
- WAIT_DATA: phase counter clears on entry. DATA_VALID_IN=1 does the following:
  - sum += zero-extended data; good++; attempt++;
  - min/max update;
  - then DONE if attempt==N, else WAIT_START.
  - Timeout moves to RECOVER.
- DATA_VALID_IN outside WAIT_DATA is ignored.
- RECOVER: TDC_RESET_OUT high for exactly RECOVER_CYCLES cycles. On the timeout path, tmo++ and attempt++ (both saturating). After the pulse: DONE if attempt==N, else WAIT_START. If entered via abort, go to IDLE with no result.
- DONE: RESULT_VALID_OUT=1. All RESULT_* outputs are stable until RESULT_ACK_IN=1. Then RESULT_VALID_OUT drops next cycle and state returns to IDLE. RESULT_* retain their values afterwards. ACK outside DONE is ignored.
- ABORT_IN in WAIT_START/WAIT_STOP/WAIT_DATA moves to RECOVER (abort flag set). It is ignored in IDLE, RECOVER and DONE.
- Priority within a cycle: ABORT_IN > data/edge event > timeout.
- Arithmetic: sum cannot overflow because its width is DATA_W+SHOT_W. Counters are SHOT_W wide. A burst with 0 good shots reports min=all ones, max=0, sum=0.
- RESET_IN mid-burst returns to the reset state on the next edge. No TDC reset pulse is emitted by the controller.

Decomposition:
- Shared package tdc_pkg holds:
  - state encoding: IDLE, WAIT_START, WAIT_STOP, WAIT_DATA, RECOVER, DONE;
  - default widths DATA_W/SHOT_W/TMO_W.
- One natural sub-module, tdc_burst_stats: sum/min/max/good accumulator with clear and update strobes.
- FSM, edge detectors and timeout counter stay in the top.

Test Plan:
- Clock 30 ns period, N=1, T=20:
  - ARM, start rise, stop rise 2 cycles later, DATA_VALID with 0x0123;
  - expect one START_OUT pulse and one STOP_OUT pulse;
  - RESULT_VALID with SUM=0x000123, MIN=MAX=0x0123, GOOD=1, TMO=0;
  - holds until ACK, then IDLE.
- N=3 with data 10, 30, 20 -> SUM=60, MIN=10, MAX=30, GOOD=3, TMO=0.
- N=2, T=5, first shot has no stop:
  - TDC_RESET_OUT high for exactly 4 cycles after 5 cycles in WAIT_STOP;
  - second shot returns 7;
  - result GOOD=1, TMO=1, SUM=7, MIN=MAX=7.
- Start held high for 10 cycles and start/stop rising together:
  - exactly one START_OUT pulse, no STOP_OUT;
  - later stop rise then gives STOP_OUT;
  - DATA_VALID in IDLE does not alter results.
- ABORT_IN in WAIT_DATA:
  - 4-cycle TDC reset, then IDLE;
  - RESULT_VALID never asserts;
  - ARM with NUM_SHOTS_IN=0 leaves BUSY_OUT=0.
- RESET_IN asserted in WAIT_STOP -> next cycle all outputs 0, MIN=0xFFFF, state IDLE; a new burst then completes normally.
